// File: rtl/seq_display_pkg.sv
// Shared definitions for the scrolling digit-sequence display.
// Provides the mode encoding, the active-low seven-segment codes ({g,f,e,d,c,b,a})
// and a constant clog2 helper for sizing the index and prescaler.
package seq_display_pkg;

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        AUTO   = 2'd1,
        HELD   = 2'd2
    } state_t;

    localparam logic [6:0] N0    = 7'b1000000;
    localparam logic [6:0] N1    = 7'b1111001;
    localparam logic [6:0] N2    = 7'b0100100;
    localparam logic [6:0] N3    = 7'b0110000;
    localparam logic [6:0] N4    = 7'b0011001;
    localparam logic [6:0] N5    = 7'b0010010;
    localparam logic [6:0] N6    = 7'b0000010;
    localparam logic [6:0] N7    = 7'b1111000;
    localparam logic [6:0] N8    = 7'b0000000;
    localparam logic [6:0] N9    = 7'b0010000;
    localparam logic [6:0] BLANK = 7'b1111111;

    // Smallest r with 2**r >= v (minimum 1 so single-bit widths stay legal).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

endpackage

// File: rtl/seq_display_fsm_seg7_decode.sv
// Combinational digit to seven-segment decoder.
// Ports: digit (4-bit value), seg_c (active-low {g,f,e,d,c,b,a}; 10-15 blank).
module seg7_decode
    import seq_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = BLANK;
        case (digit)
            4'd0: seg_c = N0;
            4'd1: seg_c = N1;
            4'd2: seg_c = N2;
            4'd3: seg_c = N3;
            4'd4: seg_c = N4;
            4'd5: seg_c = N5;
            4'd6: seg_c = N6;
            4'd7: seg_c = N7;
            4'd8: seg_c = N8;
            4'd9: seg_c = N9;
            default: seg_c = BLANK;
        endcase
    end

endmodule

// File: rtl/seq_display_fsm.sv
// Steps through a DEPTH-entry digit sequence (manual step or prescaled auto tick,
// forward or backward) and shows a NUM_DISP-wide scrolling window on HEX displays.
// Optional macro SEQ_WRITE_EN: makes the sequence a writable register array
// (wr_en/wr_addr/wr_data), reloaded from SEQ on reset.
// Ports: clk, reset_n (sync, active-low), step, dir (1=fwd), run, hold,
//        hex (display d at [7d+:7]), idx (entry on display 0), wrap (1-cycle pulse).
module seq_display_fsm
    import seq_display_pkg::*;
#(
    parameter int unsigned             DEPTH    = 5,
    parameter int unsigned             NUM_DISP = 1,
    parameter int unsigned             PRESCALE = 50000000,
    parameter logic [4*DEPTH-1:0]      SEQ      = 20'h38975
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       step,
    input  logic                       dir,
    input  logic                       run,
    input  logic                       hold,
`ifdef SEQ_WRITE_EN
    input  logic                       wr_en,
    input  logic [clog2(DEPTH)-1:0]    wr_addr,
    input  logic [3:0]                 wr_data,
`endif
    output logic [7*NUM_DISP-1:0]      hex,
    output logic [clog2(DEPTH)-1:0]    idx,
    output logic                       wrap
);

    localparam int unsigned IW = clog2(DEPTH);
    localparam int unsigned PW = clog2(PRESCALE);

    state_t                state;
    state_t                state_next;
    logic [PW-1:0]         pcnt;
    logic [PW-1:0]         pcnt_cur;
    logic [PW-1:0]         pcnt_next;
    logic                  adv;
    logic [IW-1:0]         idx_next;
    logic                  wrap_next;
    logic [7*NUM_DISP-1:0] hex_next;
    logic [3:0]            seq_next [DEPTH];

`ifdef SEQ_WRITE_EN
    logic [3:0] seq_mem [DEPTH];

    // Next sequence contents: reset reload, else a write to an in-range address.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            seq_next[i] = seq_mem[i];
            if (!reset_n) begin
                seq_next[i] = SEQ[4*i +: 4];
            end else if (wr_en && (wr_addr == IW'(i))) begin
                seq_next[i] = wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            seq_mem[i] <= seq_next[i];
        end
    end
`else
    // Constant sequence.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            seq_next[i] = SEQ[4*i +: 4];
        end
    end
`endif

    // Mode, prescaler and index update for this cycle.
    always_comb begin
        state_next = MANUAL;
        pcnt_cur   = pcnt;
        pcnt_next  = '0;
        adv        = 1'b0;
        idx_next   = idx;
        wrap_next  = 1'b0;

        if (hold) begin
            state_next = HELD;
            pcnt_next  = pcnt;
        end else if (run) begin
            state_next = AUTO;
            // Coming from MANUAL starts a fresh count; returning from HELD resumes
            // where the count was frozen.
            pcnt_cur   = (state == MANUAL) ? '0 : pcnt;
            adv        = (pcnt_cur == PW'(PRESCALE - 1));
            pcnt_next  = adv ? '0 : pcnt_cur + 1'b1;
        end else begin
            adv        = step;
        end

        if (!reset_n) begin
            idx_next = '0;
        end else if (adv) begin
            if (dir) begin
                if (idx == IW'(DEPTH - 1)) begin
                    idx_next  = '0;
                    wrap_next = 1'b1;
                end else begin
                    idx_next  = idx + 1'b1;
                end
            end else begin
                if (idx == '0) begin
                    idx_next  = IW'(DEPTH - 1);
                    wrap_next = 1'b1;
                end else begin
                    idx_next  = idx - 1'b1;
                end
            end
        end
    end

    // Window: display d shows entry (idx_next + d) mod DEPTH; d < DEPTH so one subtract suffices.
    for (genvar d = 0; d < int'(NUM_DISP); d++) begin : g_disp
        logic [IW:0]   sum;
        logic [IW-1:0] ent;
        logic [6:0]    seg;

        always_comb begin
            sum = {1'b0, idx_next} + (IW+1)'(d);
            ent = (sum >= (IW+1)'(DEPTH)) ? IW'(sum - (IW+1)'(DEPTH)) : IW'(sum);
        end

        seg7_decode u_dec (
            .digit (seq_next[ent]),
            .seg_c (seg)
        );

        assign hex_next[7*d +: 7] = seg;
    end

    // Output and state registers; hex_next already reflects reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= MANUAL;
            pcnt  <= '0;
            idx   <= '0;
            wrap  <= 1'b0;
        end else begin
            state <= state_next;
            pcnt  <= pcnt_next;
            idx   <= idx_next;
            wrap  <= wrap_next;
        end
        hex <= hex_next;
    end

endmodule

// File: tb/tb_seq_display_fsm.sv
// Self-checking bench for seq_display_fsm (DEPTH=5, NUM_DISP=2, PRESCALE=4, SEQ 5,7,9,8,3).
module tb_seq_display_fsm;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        step;
    logic        dir;
    logic        run;
    logic        hold;
    logic [13:0] hex;
    logic [2:0]  idx;
    logic        wrap;
`ifdef SEQ_WRITE_EN
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [3:0]  wr_data;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_display_fsm #(
        .DEPTH    (5),
        .NUM_DISP (2),
        .PRESCALE (4),
        .SEQ      (20'h38975)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .step    (step),
        .dir     (dir),
        .run     (run),
        .hold    (hold),
`ifdef SEQ_WRITE_EN
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
`endif
        .hex     (hex),
        .idx     (idx),
        .wrap    (wrap)
    );

    // Hand-computed windows {display1, display0} for idx 0..4.
    localparam logic [13:0] H0 = {7'b1111000, 7'b0010010};
    localparam logic [13:0] H1 = {7'b0010000, 7'b1111000};
    localparam logic [13:0] H2 = {7'b0000000, 7'b0010000};
    localparam logic [13:0] H3 = {7'b0110000, 7'b0000000};
    localparam logic [13:0] H4 = {7'b0010010, 7'b0110000};

    typedef struct {
        logic        rst_n;
        logic        stp;
        logic        dr;
        logic        rn;
        logic        hld;
        logic [2:0]  e_idx;
        logic [13:0] e_hex;
        logic        e_wrap;
    } vec_t;

    vec_t vecs [13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [13:0] win(input int i);
        case (i)
            0: return H0;
            1: return H1;
            2: return H2;
            3: return H3;
            default: return H4;
        endcase
    endfunction

    initial begin
        int exp_i;
        reset_n = 1'b0; step = 1'b0; dir = 1'b1; run = 1'b0; hold = 1'b0;
`ifdef SEQ_WRITE_EN
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
`endif

        //            rst  stp dir run hld  idx   hex  wrap
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, H0, 1'b0}; // reset
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, H1, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, H2, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, H3, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, H4, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, H0, 1'b1}; // forward wrap
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, H0, 1'b0}; // wrap is one cycle
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, H0, 1'b0}; // dir change alone
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, H4, 1'b1}; // backward wrap
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, H4, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4, H4, 1'b0}; // hold beats step
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, H3, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, H4, 1'b0};

        for (int i = 0; i < 13; i++) begin
            reset_n = vecs[i].rst_n; step = vecs[i].stp; dir = vecs[i].dr;
            run = vecs[i].rn; hold = vecs[i].hld;
            tick();
            chk($sformatf("vec%0d_idx", i), 32'(idx), 32'(vecs[i].e_idx));
            chk($sformatf("vec%0d_hex", i), 32'(hex), 32'(vecs[i].e_hex));
            chk($sformatf("vec%0d_wrap", i), 32'(wrap), 32'(vecs[i].e_wrap));
        end

        // Auto mode from idx=4, step held high; hold for 3 cycles in the third period.
        // Advances expected at run cycles 4, 8 and 15 (12 + 3 held cycles).
        run = 1'b1; step = 1'b1; dir = 1'b1;
        exp_i = 4;
        for (int k = 1; k <= 17; k++) begin
            hold = (k >= 11 && k <= 13);
            tick();
            if (k == 4 || k == 8 || k == 15) exp_i = (exp_i + 1) % 5;
            chk($sformatf("auto%0d_idx", k), 32'(idx), 32'(exp_i));
            chk($sformatf("auto%0d_wrap", k), 32'(wrap), 32'(k == 4));
        end
        hold = 1'b0;
        chk("auto_hex", 32'(hex), 32'(win(exp_i)));

        // Reset mid-count with run high: reset wins.
        reset_n = 1'b0;
        tick();
        chk("rst_run_idx", 32'(idx), 32'd0);
        chk("rst_run_hex", 32'(hex), 32'(H0));
        chk("rst_run_wrap", 32'(wrap), 32'd0);
        // Back in MANUAL: one step advances.
        reset_n = 1'b1; run = 1'b0; step = 1'b1;
        tick();
        chk("post_rst_manual", 32'(idx), 32'd1);
        // Fresh prescaler: advance on the fourth run cycle, not earlier.
        run = 1'b1; step = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("post_rst_auto%0d", k), 32'(idx), (k == 4) ? 32'd2 : 32'd1);
        end
        run = 1'b0;

`ifdef SEQ_WRITE_EN
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 4'hA;
        tick();
        chk("wr_blank_d1", 32'(hex[13:7]), 32'(7'b1111111));
        chk("wr_blank_d0", 32'(hex[6:0]), 32'(7'b0010010));
        // Write together with an advance: idx=1 shows entry1 (blank), entry2 becomes 1.
        wr_addr = 3'd2; wr_data = 4'h1; step = 1'b1; dir = 1'b1;
        tick();
        chk("wr_adv_idx", 32'(idx), 32'd1);
        chk("wr_adv_hex", 32'(hex), 32'({7'b1111001, 7'b1111111}));
        // Out-of-range address is ignored.
        wr_addr = 3'd7; wr_data = 4'h0; step = 1'b0;
        tick();
        chk("wr_oor_hex", 32'(hex), 32'({7'b1111001, 7'b1111111}));
        wr_en = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("wr_restore_hex", 32'(hex), 32'(H0));
        step = 1'b1;
        tick();
        chk("wr_restore_next", 32'(hex), 32'(H1));
        step = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
